uart_frame_tx: RTL and testbench



---
 rtl/uart_frame_tx.sv | 143 ++++++++++++++
 tb/tb_uart_frame_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: 8N1 command-frame transmitter with a write-side byte
// FIFO, CTSn flow control and terminator (end-of-frame) detection.
module uart_frame_tx #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV = 32,
  parameter logic [DATA_W-1:0] TERM_CHAR = 8'h00
) (
  input  logic                          PCLK,
  input  logic                          RESET,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          CTSn,
  output logic                          TXD,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] tx_byte;
  logic [BW-1:0]     baud_cnt;
  logic [CW-1:0]     bit_cnt;
  logic [1:0]        cts_sync;

  logic push, pop, cts_ok, can_go;
  logic baud_last, bit_last;
  logic txd_n, fd_n;

  // Ready comes from the registered level only: a pop never frees a slot
  // for a write in the same cycle.
  assign wr_ready  = (fifo_level != LW'(FIFO_DEPTH));
  assign push      = wr_valid & wr_ready;
  assign cts_ok    = ~cts_sync[1];
  assign can_go    = (fifo_level != '0) & cts_ok;
  assign baud_last = (baud_cnt == BW'(BAUD_DIV - 1));
  assign bit_last  = (bit_cnt == CW'(DATA_W - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    fd_n    = 1'b0;
    txd_n   = 1'b1;
    unique case (state)
      IDLE: begin
        if (can_go) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        txd_n = 1'b0;
        if (baud_last) state_n = DATA;
      end
      DATA: begin
        txd_n = shift[0];
        if (baud_last && bit_last) state_n = STOP;
      end
      STOP: begin
        if (baud_last) begin
          fd_n = (tx_byte == TERM_CHAR);
          // Flow control is only honoured here, between frames.
          if (can_go) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state      <= IDLE;
      TXD        <= 1'b1;
      frame_done <= 1'b0;
      cts_sync   <= 2'b11;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      shift      <= '0;
      tx_byte    <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
    end else begin
      state      <= state_n;
      TXD        <= txd_n;
      frame_done <= fd_n;
      cts_sync   <= {cts_sync[0], CTSn};
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        fifo_level <= fifo_level + LW'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LW'(1);
      end
      if (pop) begin
        shift    <= mem[rd_ptr];
        tx_byte  <= mem[rd_ptr];
        baud_cnt <= '0;
      end else if (state == IDLE) begin
        baud_cnt <= '0;
      end else if (baud_last) begin
        baud_cnt <= '0;
        if (state == START) begin
          bit_cnt <= '0;
        end else if (state == DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + CW'(1);
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed vectors and frame-level sequences for
// uart_frame_tx, checked against per-edge output history.
module tb_uart_frame_tx;

  localparam int LW = 5;
  localparam int BD = 32;
  localparam int HN = 20000;

  logic          PCLK = 1'b0;
  logic          RESET = 1'b1;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          CTSn = 1'b0;
  logic          TXD;
  logic          busy;
  logic          frame_done;
  logic [LW-1:0] fifo_level;

  uart_frame_tx #(
    .DATA_W(8),
    .FIFO_DEPTH(16),
    .BAUD_DIV(BD),
    .TERM_CHAR(8'h00)
  ) dut (
    .PCLK(PCLK),
    .RESET(RESET),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .CTSn(CTSn),
    .TXD(TXD),
    .busy(busy),
    .frame_done(frame_done),
    .fifo_level(fifo_level)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_fail = 0;
  int ecnt = 0;

  logic          txd_h [HN];
  logic          busy_h [HN];
  logic          fd_h [HN];
  logic          rdy_h [HN];
  logic [LW-1:0] lvl_h [HN];

  // hist[n] holds the outputs seen after rising edge n
  always @(negedge PCLK) begin
    if (ecnt < HN - 1) begin
      txd_h[ecnt+1]  <= TXD;
      busy_h[ecnt+1] <= busy;
      fd_h[ecnt+1]   <= frame_done;
      rdy_h[ecnt+1]  <= wr_ready;
      lvl_h[ecnt+1]  <= fifo_level;
    end
    ecnt <= ecnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    logic       fd;
  } vec_t;

  vec_t vt [5];
  logic [7:0] t2 [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // returns just after rising edge n (time #1 past it)
  task automatic goto_edge(input int n);
    @(posedge PCLK);
    #1;
    while (ecnt + 1 < n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    wr_valid = 1'b0;
    repeat (2) begin
      @(posedge PCLK);
      #1;
    end
    RESET = 1'b0;
  endtask

  function automatic logic [9:0] line_at(input int s);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = txd_h[s + BD*i + BD/2];
    return r;
  endfunction

  function automatic int cnt_busy(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (busy_h[i]) c++;
    return c;
  endfunction

  function automatic int cnt_fd(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (fd_h[i]) c++;
    return c;
  endfunction

  function automatic int first_low(input int a, input int b);
    for (int i = a; i <= b; i++) if (txd_h[i] === 1'b0) return i;
    return -1;
  endfunction

  initial begin
    int e;
    int c;
    int acc;

    vt[0] = '{8'h55, 10'b1010101010, 1'b0};
    vt[1] = '{8'h00, 10'b1000000000, 1'b1};
    vt[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vt[3] = '{8'h4B, 10'b1010010110, 1'b0};
    vt[4] = '{8'h81, 10'b1100000010, 1'b0};
    t2 = '{8'h55, 8'h41, 8'h52, 8'h54, 8'h28, 8'h00};

    goto_edge(3);
    RESET = 1'b0;
    chk("rst_txd", 32'(txd_h[2]), 1);
    chk("rst_busy", 32'(busy_h[2]), 0);
    chk("rst_fd", 32'(fd_h[2]), 0);
    chk("rst_lvl", 32'(lvl_h[2]), 0);
    chk("rst_rdy", 32'(rdy_h[2]), 1);

    // single-frame vectors, CTSn low
    for (int v = 0; v < 5; v++) begin
      goto_edge(ecnt + 3);
      wr_data = vt[v].data;
      wr_valid = 1'b1;
      e = ecnt + 2;
      goto_edge(e);
      wr_valid = 1'b0;
      goto_edge(e + 342);
      chk($sformatf("v%0d_lvl0", v), 32'(lvl_h[e]), 1);
      chk($sformatf("v%0d_lvl1", v), 32'(lvl_h[e+1]), 0);
      chk($sformatf("v%0d_lat", v), first_low(e, e + 340) - e, 2);
      chk($sformatf("v%0d_line", v), 32'(line_at(e + 2)),
          32'(vt[v].line));
      chk($sformatf("v%0d_busy", v), cnt_busy(e, e + 340), 320);
      chk($sformatf("v%0d_fdn", v), cnt_fd(e, e + 340), 32'(vt[v].fd));
      chk($sformatf("v%0d_fdat", v), 32'(fd_h[e+321]), 32'(vt[v].fd));
    end

    // "UART(" + NUL back to back
    goto_edge(ecnt + 3);
    e = ecnt + 2;
    for (int j = 0; j < 6; j++) begin
      wr_data = t2[j];
      wr_valid = 1'b1;
      goto_edge(ecnt + 2);
    end
    wr_valid = 1'b0;
    goto_edge(e + 1942);
    chk("b2b_busy", cnt_busy(e, e + 1940), 1920);
    chk("b2b_bend", 32'(busy_h[e+1920]), 1);
    chk("b2b_bidle", 32'(busy_h[e+1921]), 0);
    chk("b2b_fdn", cnt_fd(e, e + 1940), 1);
    chk("b2b_fdat", 32'(fd_h[e+1921]), 1);
    for (int j = 0; j < 6; j++)
      chk($sformatf("b2b_byte%0d", j), 32'(line_at(e + 2 + 320*j)),
          32'({1'b1, t2[j], 1'b0}));

    // blocked by CTSn: fill, overflow attempt, then release
    CTSn = 1'b1;
    do_reset();
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'h30 + 8'(i);
      wr_valid = 1'b1;
      if (wr_ready) acc++;
      goto_edge(ecnt + 2);
    end
    wr_valid = 1'b0;
    e = ecnt + 1;
    goto_edge(e + 12);
    chk("full_acc", acc, 16);
    chk("full_rdy", 32'(rdy_h[e+10]), 0);
    chk("full_lvl", 32'(lvl_h[e+10]), 16);
    chk("full_txd", first_low(e - 17, e + 10), -1);
    chk("full_busy", cnt_busy(e - 17, e + 10), 0);
    c = ecnt + 1;
    CTSn = 1'b0;
    goto_edge(c + 4 + 16*320 + 20);
    chk("cts_lat", first_low(c, c + 20) - c, 4);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("drain_lvl%0d", j), 32'(lvl_h[c+3+320*j]), 15 - j);
      chk($sformatf("drain_byte%0d", j), 32'(line_at(c + 4 + 320*j)),
          32'({1'b1, 8'h30 + 8'(j), 1'b0}));
    end
    chk("drain_idle", 32'(busy_h[c+4+16*320+10]), 0);

    // CTSn raised mid-frame
    do_reset();
    e = ecnt + 2;
    wr_data = 8'h47;
    wr_valid = 1'b1;
    goto_edge(e);
    wr_data = 8'h50;
    goto_edge(e + 1);
    wr_valid = 1'b0;
    goto_edge(e + 2 + BD*5);
    CTSn = 1'b1;
    goto_edge(e + 360);
    chk("mid_line", 32'(line_at(e + 2)), 32'({1'b1, 8'h47, 1'b0}));
    chk("mid_busy", cnt_busy(e, e + 350), 320);
    chk("mid_txd", 32'(txd_h[e+330]), 1);
    chk("mid_lvl", 32'(lvl_h[e+330]), 1);
    chk("mid_stay", first_low(e + 330, e + 358), -1);
    c = ecnt + 1;
    CTSn = 1'b0;
    goto_edge(c + 4 + 320 + 10);
    chk("res_lat", first_low(c, c + 20) - c, 4);
    chk("res_lvl", 32'(lvl_h[c+3]), 0);
    chk("res_line", 32'(line_at(c + 4)), 32'({1'b1, 8'h50, 1'b0}));

    // full FIFO, pop coincides with a rejected write
    CTSn = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'hA0 + 8'(i);
      wr_valid = 1'b1;
      goto_edge(ecnt + 2);
    end
    wr_data = 8'hEE;
    c = ecnt + 1;
    CTSn = 1'b0;
    goto_edge(c + 3);
    wr_valid = 1'b0;
    goto_edge(c + 7);
    chk("pw_rdy_pre", 32'(rdy_h[c+2]), 0);
    chk("pw_lvl_pre", 32'(lvl_h[c+2]), 16);
    chk("pw_lvl_pop", 32'(lvl_h[c+3]), 15);
    chk("pw_rdy_post", 32'(rdy_h[c+3]), 1);
    chk("pw_lvl_hold", 32'(lvl_h[c+5]), 15);

    // reset in the middle of bit 3 of 0x4B
    do_reset();
    e = ecnt + 2;
    for (int j = 0; j < 6; j++) begin
      wr_data = (j == 0) ? 8'h4B : 8'h10 + 8'(j);
      wr_valid = 1'b1;
      goto_edge(ecnt + 2);
    end
    wr_valid = 1'b0;
    goto_edge(e + 140);
    RESET = 1'b1;
    goto_edge(e + 141);
    RESET = 1'b0;
    goto_edge(e + 202);
    chk("mr_pre_lvl", 32'(lvl_h[e+139]), 5);
    chk("mr_pre_bit3", 32'(txd_h[e+139]), 1);
    chk("mr_txd", 32'(txd_h[e+141]), 1);
    chk("mr_busy", 32'(busy_h[e+141]), 0);
    chk("mr_lvl", 32'(lvl_h[e+141]), 0);
    chk("mr_fd", 32'(fd_h[e+141]), 0);
    chk("mr_rdy", 32'(rdy_h[e+141]), 1);
    chk("mr_idle_busy", cnt_busy(e + 141, e + 200), 0);
    chk("mr_idle_txd", first_low(e + 141, e + 200), -1);
    chk("mr_no_fd", cnt_fd(e, e + 200), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
